// File: rtl/sdram_pro_burst_sched.sv
// rtl/sdram_pro_burst_sched.sv - round-robin write/read burst scheduler for an SDRAM ring buffer
// Optional SCHED_RD_GUARD_EN: track stored words so reads wait for data and writes stop when the ring is full.
module sdram_pro_burst_sched #(
  parameter logic [9:0]  BURST_LEN  = 10'd256,
  parameter logic [9:0]  FIFO_DEPTH = 10'd1023,
  parameter logic [22:0] ADDR_MIN   = 23'h000000,
  parameter logic [22:0] ADDR_MAX   = 23'h7FFFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        rd_enable,
  input  logic [9:0]  wr_fifo_cnt,
  input  logic [9:0]  rd_fifo_cnt,
  input  logic        sdram_wr_ack,
  input  logic        sdram_wr_end,
  input  logic        sdram_rd_ack,
  input  logic        sdram_rd_end,
  output logic        sdram_wr_req,
  output logic [22:0] sdram_wr_addr,
  output logic        sdram_rd_req,
  output logic [22:0] sdram_rd_addr,
  output logic [9:0]  wr_burst_len,
  output logic [9:0]  rd_burst_len,
  output logic        busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_WAIT = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;

  localparam logic [23:0] BURST_W = {14'd0, BURST_LEN};
  localparam logic [23:0] MAX_W   = {1'b0, ADDR_MAX};

  logic [2:0] state;
  logic       last_wr;
  logic       wr_room;
  logic       rd_data;
  logic       wr_elig;
  logic       rd_elig;
  logic       wr_done;
  logic       rd_done;

  function automatic logic [22:0] next_addr(input logic [22:0] a);
    logic [23:0] sum;
    sum = {1'b0, a} + BURST_W;
    return (sum > MAX_W) ? ADDR_MIN : sum[22:0];
  endfunction

  assign wr_burst_len = BURST_LEN;
  assign rd_burst_len = BURST_LEN;
  assign busy         = (state != IDLE);

  // Completion includes the ack+end-together shortcut out of *_REQ.
  assign wr_done = ((state == WR_WAIT) && sdram_wr_end) ||
                   ((state == WR_REQ) && sdram_wr_ack && sdram_wr_end);
  assign rd_done = ((state == RD_WAIT) && sdram_rd_end) ||
                   ((state == RD_REQ) && sdram_rd_ack && sdram_rd_end);

`ifdef SCHED_RD_GUARD_EN
  localparam logic [23:0] REGION = MAX_W - {1'b0, ADDR_MIN} + 24'd1;

  logic [23:0] avail;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      avail <= 24'd0;
    end else if (wr_done) begin
      avail <= avail + BURST_W;
    end else if (rd_done) begin
      avail <= avail - BURST_W;
    end
  end

  assign wr_room = !(avail > (REGION - BURST_W));
  assign rd_data = (avail >= BURST_W);
`else
  assign wr_room = 1'b1;
  assign rd_data = 1'b1;
`endif

  assign wr_elig = init_end && (wr_fifo_cnt >= BURST_LEN) && wr_room;
  assign rd_elig = init_end && rd_enable && rd_data &&
                   (({1'b0, rd_fifo_cnt} + {1'b0, BURST_LEN}) <= {1'b0, FIFO_DEPTH});

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= ADDR_MIN;
      sdram_rd_addr <= ADDR_MIN;
      last_wr       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_elig && (!rd_elig || !last_wr)) begin
            state        <= WR_REQ;
            sdram_wr_req <= 1'b1;
            last_wr      <= 1'b1;
          end else if (rd_elig) begin
            state        <= RD_REQ;
            sdram_rd_req <= 1'b1;
            last_wr      <= 1'b0;
          end
        end
        WR_REQ: begin
          if (sdram_wr_ack) begin
            sdram_wr_req <= 1'b0;
            if (sdram_wr_end) begin
              sdram_wr_addr <= next_addr(sdram_wr_addr);
              state         <= IDLE;
            end else begin
              state <= WR_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (sdram_wr_end) begin
            sdram_wr_addr <= next_addr(sdram_wr_addr);
            state         <= IDLE;
          end
        end
        RD_REQ: begin
          if (sdram_rd_ack) begin
            sdram_rd_req <= 1'b0;
            if (sdram_rd_end) begin
              sdram_rd_addr <= next_addr(sdram_rd_addr);
              state         <= IDLE;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (sdram_rd_end) begin
            sdram_rd_addr <= next_addr(sdram_rd_addr);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
